imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//   Instruction-memory responder: the memory end of the core's fetch handshake (RRdy/RAddr -> RVld/RData).
//   Holds a DEPTH-word program RAM preloaded through a load port and drives LEn to release the core once
//   loading completes. Answers each accepted fetch after a fixed LATENCY and counts fetches served.
// PARAMETERS
//   ADDR_W   8  word-address width; DEPTH = 2**ADDR_W 32-bit words
//   LATENCY  1  cycles from request acceptance to RVld; legal range 1..8
//   NOP      32'h00000013  word returned for out-of-range fetch addresses (addi x0,x0,0)
// PORTS
//   clk         in   1       clock, all logic on rising edge
//   rstn        in   1       synchronous active-low reset
//   ld_valid    in   1       load-port write strobe (honoured only in LOAD state)
//   ld_addr     in   ADDR_W  load-port word address
//   ld_data     in   32      load-port write data
//   ld_done     in   1       load-complete pulse; LOAD -> IDLE
//   LEn         out  1       core enable; 1 once loading done
//   RRdy        in   1       core fetch request
//   RAddr       in   32      core fetch word address (PC, word-granular)
//   RVld        out  1       fetch response valid, single-cycle pulse
//   RData       out  32      fetched instruction word
//   err         out  1       sticky out-of-range fetch flag
//   served_cnt  out  16      responses delivered, saturating
// BEHAVIOUR
//   Reset: state=LOAD; LEn=0, RVld=0, RData=0, err=0, served_cnt=0; RAM array NOT reset (contents kept).
//   States: LOAD, IDLE, WAIT, RESP.
//   LOAD: ld_valid=1 -> mem[ld_addr]<=ld_data. ld_done=1 -> IDLE, LEn<=1 (LEn high cycle after ld_done).
//     ld_valid and ld_done same cycle: write is performed, then transition. RRdy ignored in LOAD.
//   IDLE: RRdy=1 accepts request at cycle T: latch RAddr into areg; if LATENCY==1 -> RESP,
//     else -> WAIT with cnt=LATENCY-2.
//   WAIT: cnt==0 -> RESP; else cnt--. RRdy/RAddr ignored (request already latched; RRdy dropping
//     does not cancel the response).
//   RESP: RVld=1 for exactly one cycle at T+LATENCY; RData=mem[areg[ADDR_W-1:0]] if areg[31:ADDR_W]==0,
//     else RData=NOP and err<=1. served_cnt++ (holds at 16'hFFFF). Next state IDLE.
//   RRdy is NOT sampled in RESP; earliest next acceptance is the cycle after RVld (core drops RRdy then
//     re-raises it with a new RAddr). Back-to-back throughput: one fetch per LATENCY+1 cycles minimum.
//   RData holds last response value between pulses; ld_valid outside LOAD ignored, mem unchanged.
//   LEn stays 1 from IDLE onwards until reset; err cleared only by reset.
//   Reset mid-operation (WAIT/RESP): pending response dropped, no RVld, return to LOAD with LEn=0;
//     ld_done alone (no writes) resumes with prior RAM contents.
//   RAM: one write port (load), one read port (fetch); read is registered into RData in RESP.
// TESTING
//   1 LATENCY=1: load mem[0..2]=32'h000010B7,32'h00002137,32'h000031B7, ld_done -> LEn=1 next cycle;
//     RRdy=1,RAddr=0 at T -> RVld=1 at T+1, RData=32'h000010B7; served_cnt=1.
//   2 LATENCY=3: request RAddr=2 at T -> RVld=0 at T+1,T+2; RVld=1 only at T+3, RData=32'h000031B7.
//   3 ADDR_W=8: RAddr=32'h00000100 -> RData=32'h00000013, err=1 and remains 1 after later in-range fetches.
//   4 RRdy=1 during LOAD -> no RVld; after ld_done, ld_valid addr 0 data 32'hFFFFFFFF -> fetch 0 still 32'h000010B7.
//   5 rstn low one cycle during WAIT -> no RVld, LEn=0, served_cnt=0; ld_done only -> fetch 0 returns 32'h000010B7.
//   6 ld_valid(addr 5, 32'hDEADBEEF) with ld_done same cycle -> fetch 5 returns 32'hDEADBEEF; run core with
//     this responder for 20 fetches -> RVld never two consecutive cycles, served_cnt=20.

Source files
------------

// File: rtl/imem_responder_if.sv
// Fetch handshake between the core (master) and the instruction memory (slave).
interface imem_responder_if;
  logic        RRdy;
  logic [31:0] RAddr;
  logic        RVld;
  logic [31:0] RData;

  modport master (
    output RRdy,
    output RAddr,
    input  RVld,
    input  RData
  );

  modport slave (
    input  RRdy,
    input  RAddr,
    output RVld,
    output RData
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: preloaded program RAM answering core fetches after a fixed latency.
// Releases the core via LEn once loading completes and counts responses served.
module imem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 1,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_done,
  output logic              LEn,
  imem_responder_if.slave   fetch,
  output logic              err,
  output logic [15:0]       served_cnt
);

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned CNT_W_MAX = 16;
  localparam int unsigned WAIT_INIT = (LATENCY > 1) ? (LATENCY - 2) : 0;

  typedef enum logic [1:0] {
    S_LOAD,
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  areg_q, areg_d;
  logic               len_q, len_d;
  logic               rvld_q, rvld_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [CNT_W_MAX-1:0] served_q, served_d;

  logic [DATA_W-1:0]  fetch_addr_c;
  logic               in_range_c;
  logic               enter_resp_c;

  // Program RAM: written only while loading, never reset.
  always_ff @(posedge clk) begin
    if (rstn && (state_q == S_LOAD) && ld_valid) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // The accepting cycle reads the live request address; later cycles use the latched one.
  assign fetch_addr_c = (state_q == S_IDLE) ? fetch.RAddr : areg_q;
  assign in_range_c   = (fetch_addr_c[DATA_W-1:ADDR_W] == '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_LOAD;
      cnt_q    <= '0;
      areg_q   <= '0;
      len_q    <= 1'b0;
      rvld_q   <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      areg_q   <= areg_d;
      len_q    <= len_d;
      rvld_q   <= rvld_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      served_q <= served_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    areg_d       = areg_q;
    len_d        = len_q;
    rvld_d       = 1'b0;
    rdata_d      = rdata_q;
    err_d        = err_q;
    served_d     = served_q;
    enter_resp_c = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (ld_done) begin
          state_d = S_IDLE;
          len_d   = 1'b1;
        end
      end
      S_IDLE: begin
        if (fetch.RRdy) begin
          areg_d = fetch.RAddr;
          if (LATENCY == 1) begin
            enter_resp_c = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_INIT);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase

    // Response data, error flag and count are registered on entry so RVld coincides with RESP.
    if (enter_resp_c) begin
      state_d = S_RESP;
      rvld_d  = 1'b1;
      if (in_range_c) begin
        rdata_d = mem[fetch_addr_c[ADDR_W-1:0]];
      end else begin
        rdata_d = NOP;
        err_d   = 1'b1;
      end
      if (served_q != {CNT_W_MAX{1'b1}}) begin
        served_d = served_q + CNT_W_MAX'(1);
      end
    end
  end

  assign LEn         = len_q;
  assign fetch.RVld  = rvld_q;
  assign fetch.RData = rdata_q;
  assign err         = err_q;
  assign served_cnt  = served_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: LATENCY=1 and LATENCY=3 instances sharing the load port,
// responses checked against a queue of expected words.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ld_valid;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_done;

  logic        rrdy  [2];
  logic [31:0] raddr [2];
  logic        rvld  [2];
  logic [31:0] rdata [2];
  logic        len   [2];
  logic        err   [2];
  logic [15:0] served [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [256];
  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];
  logic [31:0] addr_tab [4];

  imem_responder_if bus0 ();
  imem_responder_if bus1 ();

  assign bus0.RRdy  = rrdy[0];
  assign bus0.RAddr = raddr[0];
  assign rvld[0]    = bus0.RVld;
  assign rdata[0]   = bus0.RData;
  assign bus1.RRdy  = rrdy[1];
  assign bus1.RAddr = raddr[1];
  assign rvld[1]    = bus1.RVld;
  assign rdata[1]   = bus1.RData;

  imem_responder #(.ADDR_W(8), .LATENCY(1), .NOP(32'h0000_0013)) u_dut0 (
    .clk        (clk),
    .rstn       (rstn),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_done    (ld_done),
    .LEn        (len[0]),
    .fetch      (bus0.slave),
    .err        (err[0]),
    .served_cnt (served[0])
  );

  imem_responder #(.ADDR_W(8), .LATENCY(3), .NOP(32'h0000_0013)) u_dut1 (
    .clk        (clk),
    .rstn       (rstn),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_done    (ld_done),
    .LEn        (len[1]),
    .fetch      (bus1.slave),
    .err        (err[1]),
    .served_cnt (served[1])
  );

  always #5 clk = ~clk;

  // Response monitors: pop the scoreboard on every RVld and flag back-to-back pulses.
  logic        prev0 = 1'b0;
  logic        prev1 = 1'b0;
  logic [31:0] e0, e1;

  always @(negedge clk) begin
    if (rvld[0] === 1'b1) begin
      checks++;
      if (exp0.size() == 0) begin
        errors++;
        $display("FAIL rsp0_unexpected: RVld=1 RData=%h, required no response", rdata[0]);
      end else begin
        e0 = exp0.pop_front();
        if (rdata[0] !== e0) begin
          errors++;
          $display("FAIL rsp0_data: RData=%h, required %h", rdata[0], e0);
        end
      end
      checks++;
      if (prev0 === 1'b1) begin
        errors++;
        $display("FAIL rsp0_consecutive: RVld high two cycles, required single pulse");
      end
    end
    prev0 = rvld[0];
  end

  always @(negedge clk) begin
    if (rvld[1] === 1'b1) begin
      checks++;
      if (exp1.size() == 0) begin
        errors++;
        $display("FAIL rsp1_unexpected: RVld=1 RData=%h, required no response", rdata[1]);
      end else begin
        e1 = exp1.pop_front();
        if (rdata[1] !== e1) begin
          errors++;
          $display("FAIL rsp1_data: RData=%h, required %h", rdata[1], e1);
        end
      end
      checks++;
      if (prev1 === 1'b1) begin
        errors++;
        $display("FAIL rsp1_consecutive: RVld high two cycles, required single pulse");
      end
    end
    prev1 = rvld[1];
  end

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic ld_write(input logic [7:0] a, input logic [31:0] d, input logic done);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_done  = done;
    model_mem[a] = d;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_done  = 1'b0;
  endtask

  task automatic ld_finish();
    @(negedge clk);
    ld_done = 1'b1;
    @(posedge clk);
    #1;
    ld_done = 1'b0;
  endtask

  // Issues one fetch in an IDLE cycle; returns cycles from acceptance edge to RVld (0 = timeout).
  task automatic fetch(input int idx, input logic [31:0] a, input logic [31:0] expd,
                       input logic hold, output int lat);
    lat = 0;
    @(negedge clk);
    rrdy[idx]  = 1'b1;
    raddr[idx] = a;
    if (idx == 0) exp0.push_back(expd);
    else          exp1.push_back(expd);
    @(posedge clk);
    #1;
    if (!hold) begin
      rrdy[idx]  = 1'b0;
      raddr[idx] = $urandom;
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (rvld[idx] === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (hold) begin
      @(posedge clk);
      #1;
      rrdy[idx] = 1'b0;
    end
  endtask

  task automatic test_reset();
    pulse_reset();
    pulse_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({len[i], rvld[i], err[i]} !== 3'b000 || rdata[i] !== 32'h0 || served[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset_state[%0d]: LEn=%b RVld=%b err=%b RData=%h served=%h, required all zero",
                 i, len[i], rvld[i], err[i], rdata[i], served[i]);
      end
    end
  endtask

  task automatic test_load();
    int seen;
    seen = 0;
    rrdy[0] = 1'b1; raddr[0] = 32'h0;
    rrdy[1] = 1'b1; raddr[1] = 32'h0;
    ld_write(8'd0, 32'h0000_10B7, 1'b0);
    ld_write(8'd1, 32'h0000_2137, 1'b0);
    ld_write(8'd2, 32'h0000_31B7, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rvld[0] === 1'b1 || rvld[1] === 1'b1) seen++;
    end
    rrdy[0] = 1'b0;
    rrdy[1] = 1'b0;
    checks++;
    if (seen != 0 || len[0] !== 1'b0 || len[1] !== 1'b0) begin
      errors++;
      $display("FAIL load_ignores_fetch: RVld cycles=%0d LEn=%b%b, required 0 and LEn=00", seen, len[0], len[1]);
    end
    ld_finish();
    @(negedge clk);
    checks++;
    if (len[0] !== 1'b1 || len[1] !== 1'b1) begin
      errors++;
      $display("FAIL len_after_done: LEn=%b%b, required 11", len[0], len[1]);
    end
  endtask

  task automatic test_fetch_lat1();
    int lat;
    fetch(0, 32'h0, model_mem[0], 1'b0, lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL lat1_latency: RVld after %0d cycles, required 1", lat);
    end
    checks++;
    if (served[0] !== 16'd1 || served[1] !== 16'd0) begin
      errors++;
      $display("FAIL lat1_served: served=%0d/%0d, required 1/0", served[0], served[1]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rdata[0] !== 32'h0000_10B7) begin
      errors++;
      $display("FAIL rdata_hold: RData=%h, required 000010b7", rdata[0]);
    end
  endtask

  task automatic test_latency3();
    int lat;
    fetch(1, 32'h2, 32'h0000_31B7, 1'b0, lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL lat3_latency: RVld after %0d cycles, required 3", lat);
    end
    checks++;
    if (served[1] !== 16'd1) begin
      errors++;
      $display("FAIL lat3_served: served=%0d, required 1", served[1]);
    end
  endtask

  task automatic test_out_of_range();
    int lat0, lat1, lat2, lat3;
    fork
      begin
        fetch(0, 32'h0000_0100, 32'h0000_0013, 1'b0, lat0);
        fetch(0, 32'h0000_0001, 32'h0000_2137, 1'b1, lat2);
      end
      begin
        fetch(1, 32'h8000_0000, 32'h0000_0013, 1'b1, lat1);
        fetch(1, 32'h0000_0001, 32'h0000_2137, 1'b0, lat3);
      end
    join
    checks++;
    if (lat0 != 1 || lat2 != 1 || lat1 != 3 || lat3 != 3) begin
      errors++;
      $display("FAIL oor_latency: %0d %0d %0d %0d, required 1 1 3 3", lat0, lat2, lat1, lat3);
    end
    checks++;
    if (err[0] !== 1'b1 || err[1] !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b%b, required 11", err[0], err[1]);
    end
  endtask

  task automatic test_ld_outside_load();
    int lat0, lat1;
    @(negedge clk);
    ld_valid = 1'b1;
    ld_addr  = 8'd0;
    ld_data  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    fork
      fetch(0, 32'h0, 32'h0000_10B7, 1'b0, lat0);
      fetch(1, 32'h0, 32'h0000_10B7, 1'b0, lat1);
    join
    checks++;
    if (lat0 != 1 || lat1 != 3) begin
      errors++;
      $display("FAIL ld_ignored_latency: %0d %0d, required 1 3", lat0, lat1);
    end
  endtask

  task automatic test_reset_midwait();
    int seen, lat0, lat1;
    seen = 0;
    @(negedge clk);
    rrdy[1]  = 1'b1;
    raddr[1] = 32'h2;
    @(posedge clk);
    #1;
    rrdy[1] = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rvld[1] === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midwait_dropped: RVld cycles=%0d, required 0", seen);
    end
    checks++;
    if (len[1] !== 1'b0 || served[1] !== 16'd0 || err[1] !== 1'b0 || served[0] !== 16'd0) begin
      errors++;
      $display("FAIL midwait_state: LEn=%b served=%0d err=%b served0=%0d, required 0 0 0 0",
               len[1], served[1], err[1], served[0]);
    end
    ld_finish();
    fork
      fetch(0, 32'h0, 32'h0000_10B7, 1'b0, lat0);
      fetch(1, 32'h0, 32'h0000_10B7, 1'b0, lat1);
    join
    checks++;
    if (lat0 != 1 || lat1 != 3) begin
      errors++;
      $display("FAIL resume_latency: %0d %0d, required 1 3", lat0, lat1);
    end
  endtask

  task automatic test_back_to_back();
    int bad0, bad1, lat0, lat1;
    bad0 = 0;
    bad1 = 0;
    pulse_reset();
    ld_write(8'd5, 32'hDEAD_BEEF, 1'b1);
    fork
      fetch(0, 32'h5, 32'hDEAD_BEEF, 1'b0, lat0);
      fetch(1, 32'h5, 32'hDEAD_BEEF, 1'b0, lat1);
    join
    fork
      begin
        for (int n = 0; n < 19; n++) begin
          int lt;
          fetch(0, addr_tab[n % 4], model_mem[addr_tab[n % 4][7:0]], 1'b1, lt);
          if (lt != 1) bad0++;
        end
      end
      begin
        for (int n = 0; n < 19; n++) begin
          int lt;
          fetch(1, addr_tab[(n + 1) % 4], model_mem[addr_tab[(n + 1) % 4][7:0]], 1'b1, lt);
          if (lt != 3) bad1++;
        end
      end
    join
    repeat (2) @(negedge clk);
    checks++;
    if (lat0 != 1 || lat1 != 3 || bad0 != 0 || bad1 != 0) begin
      errors++;
      $display("FAIL b2b_latency: first %0d/%0d, late fetches %0d/%0d, required 1/3 and 0/0",
               lat0, lat1, bad0, bad1);
    end
    checks++;
    if (served[0] !== 16'd20 || served[1] !== 16'd20) begin
      errors++;
      $display("FAIL b2b_served: served=%0d/%0d, required 20/20", served[0], served[1]);
    end
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0 || err[0] !== 1'b0 || err[1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: pending=%0d/%0d err=%b%b, required 0/0 and 00",
               exp0.size(), exp1.size(), err[0], err[1]);
    end
  endtask

  initial begin
    rstn     = 1'b0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    ld_done  = 1'b0;
    rrdy[0]  = 1'b0;
    rrdy[1]  = 1'b0;
    raddr[0] = '0;
    raddr[1] = '0;
    addr_tab[0] = 32'h0;
    addr_tab[1] = 32'h1;
    addr_tab[2] = 32'h2;
    addr_tab[3] = 32'h5;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;

    test_reset();
    test_load();
    test_fetch_lat1();
    test_latency3();
    test_out_of_range();
    test_ld_outside_load();
    test_reset_midwait();
    test_back_to_back();

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
